// File: rtl/traffic_light_controller_if.sv
// Traffic light controller I/O bundle.
// master: drives Sensor, WalkRequest, Reprogram, Selector, Time_Value and
//         observes LEDs, OneHz, WalkReq, Anode_Activate, LED_out.
// slave : the controller side of the same signals.
interface traffic_light_controller_if;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned TIME_W = 4;
   localparam int unsigned LED_W  = 7;
   localparam int unsigned AN_W   = 4;
   localparam int unsigned SEG_W  = 7;

   // Operator / road inputs
   logic              Sensor;
   logic              WalkRequest;
   logic              Reprogram;
   logic [SEL_W-1:0]  Selector;
   logic [TIME_W-1:0] Time_Value;

   // Lamp, status and display outputs
   logic [LED_W-1:0]  LEDs;
   logic              OneHz;
   logic              WalkReq;
   logic [AN_W-1:0]   Anode_Activate;
   logic [SEG_W-1:0]  LED_out;

   modport master (
      output Sensor, WalkRequest, Reprogram, Selector, Time_Value,
      input  LEDs, OneHz, WalkReq, Anode_Activate, LED_out
   );

   modport slave (
      input  Sensor, WalkRequest, Reprogram, Selector, Time_Value,
      output LEDs, OneHz, WalkReq, Anode_Activate, LED_out
   );
endinterface

// File: rtl/traffic_light_controller.sv
// Traffic light controller: main/side street lights, pedestrian walk phase,
// reprogrammable phase durations, 1 Hz tick generator and a 4-digit
// multiplexed 7-segment display (timer units, timer tens, blank, state).
// Ports:
//   clk   - system clock, rising edge
//   Reset - asynchronous active-low reset
//   bus   - slave side of traffic_light_controller_if (all other I/O)
module traffic_light_controller #(
   parameter int unsigned CLK_HZ         = 100000,
   parameter int unsigned REFRESH_CYCLES = 250
) (
   input  logic                      clk,
   input  logic                      Reset,
   traffic_light_controller_if.slave bus
);

   localparam int unsigned HALF_HZ = (CLK_HZ / 2 > 1) ? CLK_HZ / 2 : 1;
   localparam int unsigned DIV_W   = (HALF_HZ > 1) ? $clog2(HALF_HZ) : 1;
   localparam int unsigned REF_N   = (REFRESH_CYCLES > 1) ? REFRESH_CYCLES : 1;
   localparam int unsigned REF_W   = (REF_N > 1) ? $clog2(REF_N) : 1;
   localparam int unsigned TIME_W  = 4;
   localparam int unsigned LED_W   = 7;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned AN_W    = 4;

   localparam logic [TIME_W-1:0] T_BASE_DEF = 4'd6;
   localparam logic [TIME_W-1:0] T_EXT_DEF  = 4'd3;
   localparam logic [TIME_W-1:0] T_YEL_DEF  = 4'd2;

   localparam logic [SEG_W-1:0]  SEG_BLANK  = 7'b1111111;

   typedef enum logic [2:0] {
      MAIN_G  = 3'd0,
      MAIN_G2 = 3'd1,
      MAIN_Y  = 3'd2,
      WALK    = 3'd3,
      SIDE_G  = 3'd4,
      SIDE_G2 = 3'd5,
      SIDE_Y  = 3'd6
   } state_t;

   // Registered state
   state_t             state_q,       state_d;
   logic [TIME_W-1:0]  timer_q,       timer_d;
   logic [TIME_W-1:0]  t_base_q,      t_base_d;
   logic [TIME_W-1:0]  t_ext_q,       t_ext_d;
   logic [TIME_W-1:0]  t_yel_q,       t_yel_d;
   logic               sensor_pend_q, sensor_pend_d;
   logic               walk_req_q,    walk_req_d;
   logic               one_hz_q,      one_hz_d;
   logic [DIV_W-1:0]   div_q,         div_d;
   logic [REF_W-1:0]   ref_q,         ref_d;
   logic [1:0]         digit_q,       digit_d;
   logic [LED_W-1:0]   leds_q,        leds_d;
   logic [AN_W-1:0]    anode_q,       anode_d;
   logic [SEG_W-1:0]   seg_q,         seg_d;

   // Combinational helpers
   logic               tick_c;
   logic               sensor_eff_c;
   logic [TIME_W-1:0]  tv_c;
   logic [TIME_W-1:0]  units_c;
   logic [TIME_W-1:0]  tens_c;

   // Active-low segment pattern (a..g on [6:0]) for a decimal digit.
   function automatic logic [SEG_W-1:0] seg7(input logic [3:0] v);
      logic [SEG_W-1:0] s;
      s = SEG_BLANK;
      case (v)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Lamp pattern: [6] walk, [5:3] main R/Y/G, [2:0] side R/Y/G.
   function automatic logic [LED_W-1:0] led_pattern(input state_t s);
      logic [LED_W-1:0] p;
      p = 7'b0001100;
      case (s)
         MAIN_G, MAIN_G2: p = 7'b0001100;
         MAIN_Y:          p = 7'b0010100;
         WALK:            p = 7'b1100100;
         SIDE_G, SIDE_G2: p = 7'b0100001;
         SIDE_Y:          p = 7'b0100010;
         default:         p = 7'b0001100;
      endcase
      return p;
   endfunction

   // State register and all output registers
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= MAIN_G;
         timer_q       <= T_BASE_DEF;
         t_base_q      <= T_BASE_DEF;
         t_ext_q       <= T_EXT_DEF;
         t_yel_q       <= T_YEL_DEF;
         sensor_pend_q <= 1'b0;
         walk_req_q    <= 1'b0;
         one_hz_q      <= 1'b0;
         div_q         <= '0;
         ref_q         <= '0;
         digit_q       <= 2'd0;
         leds_q        <= 7'b0001100;
         anode_q       <= 4'b1110;
         seg_q         <= 7'b0100000;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         t_base_q      <= t_base_d;
         t_ext_q       <= t_ext_d;
         t_yel_q       <= t_yel_d;
         sensor_pend_q <= sensor_pend_d;
         walk_req_q    <= walk_req_d;
         one_hz_q      <= one_hz_d;
         div_q         <= div_d;
         ref_q         <= ref_d;
         digit_q       <= digit_d;
         leds_q        <= leds_d;
         anode_q       <= anode_d;
         seg_q         <= seg_d;
      end
   end

   // Next-state, timing and display logic
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      t_base_d      = t_base_q;
      t_ext_d       = t_ext_q;
      t_yel_d       = t_yel_q;
      sensor_pend_d = sensor_pend_q;
      walk_req_d    = walk_req_q;
      one_hz_d      = one_hz_q;
      div_d         = div_q;
      ref_d         = ref_q;
      digit_d       = digit_q;
      leds_d        = leds_q;
      anode_d       = anode_q;
      seg_d         = seg_q;
      units_c       = '0;
      tens_c        = '0;

      // 1 Hz divider; the tick is the cycle on which OneHz rises
      tick_c = 1'b0;
      if (div_q == DIV_W'(HALF_HZ - 1)) begin
         div_d    = '0;
         one_hz_d = ~one_hz_q;
         tick_c   = ~one_hz_q;
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      // A sensor pulse on the deciding cycle itself still counts
      sensor_eff_c = sensor_pend_q | bus.Sensor;
      tv_c = (bus.Time_Value == '0) ? TIME_W'(1) : bus.Time_Value;

      // Reprogram has priority over the tick
      if (bus.Reprogram) begin
         case (bus.Selector)
            2'b00:   t_base_d = tv_c;
            2'b01:   t_ext_d  = tv_c;
            2'b10:   t_yel_d  = tv_c;
            default: begin
               t_base_d = T_BASE_DEF;
               t_ext_d  = T_EXT_DEF;
               t_yel_d  = T_YEL_DEF;
            end
         endcase
         state_d = MAIN_G;
         timer_d = t_base_d;
      end else if (tick_c) begin
         if (timer_q <= TIME_W'(1)) begin
            case (state_q)
               MAIN_G: begin
                  state_d = MAIN_G2;
                  timer_d = sensor_eff_c ? t_ext_q : t_base_q;
               end
               MAIN_G2: begin
                  state_d = MAIN_Y;
                  timer_d = t_yel_q;
               end
               MAIN_Y: begin
                  if (walk_req_q) begin
                     state_d = WALK;
                     timer_d = t_ext_q;
                  end else begin
                     state_d = SIDE_G;
                     timer_d = t_base_q;
                  end
               end
               WALK: begin
                  state_d = SIDE_G;
                  timer_d = t_base_q;
               end
               SIDE_G: begin
                  if (bus.Sensor) begin
                     state_d = SIDE_G2;
                     timer_d = t_ext_q;
                  end else begin
                     state_d = SIDE_Y;
                     timer_d = t_yel_q;
                  end
               end
               SIDE_G2: begin
                  state_d = SIDE_Y;
                  timer_d = t_yel_q;
               end
               SIDE_Y: begin
                  state_d = MAIN_G;
                  timer_d = t_base_q;
               end
               default: begin
                  state_d = MAIN_G;
                  timer_d = t_base_q;
               end
            endcase
         end else begin
            timer_d = timer_q - TIME_W'(1);
         end
      end

      // Sensor latch: serviced by entering SIDE_G
      sensor_pend_d = sensor_pend_q | bus.Sensor;
      if (state_d == SIDE_G && state_q != SIDE_G) begin
         sensor_pend_d = 1'b0;
      end

      // Walk latch: a request on the exit cycle survives the clear
      if (state_q == WALK && state_d != WALK) begin
         walk_req_d = 1'b0;
      end
      if (bus.WalkRequest) begin
         walk_req_d = 1'b1;
      end

      leds_d = led_pattern(state_d);

      // Digit scan
      if (ref_q == REF_W'(REF_N - 1)) begin
         ref_d   = '0;
         digit_d = digit_q + 2'd1;
      end else begin
         ref_d = ref_q + REF_W'(1);
      end

      // Timer is at most 15, so a single compare splits tens and units
      if (timer_d >= TIME_W'(10)) begin
         units_c = timer_d - TIME_W'(10);
         tens_c  = TIME_W'(1);
      end else begin
         units_c = timer_d;
         tens_c  = '0;
      end

      anode_d = ~(4'b0001 << digit_d);
      case (digit_d)
         2'd0:    seg_d = seg7(units_c);
         2'd1:    seg_d = seg7(tens_c);
         2'd2:    seg_d = SEG_BLANK;
         default: seg_d = seg7({1'b0, state_d});
      endcase
   end

   assign bus.LEDs           = leds_q;
   assign bus.OneHz          = one_hz_q;
   assign bus.WalkReq        = walk_req_q;
   assign bus.Anode_Activate = anode_q;
   assign bus.LED_out        = seg_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Testbench for traffic_light_controller with a shortened second
// (CLK_HZ = 40 cycles) so full light cycles fit in a short run.
module tb_traffic_light_controller;

   localparam int unsigned CLK_HZ    = 40;
   localparam int unsigned HALF      = CLK_HZ / 2;
   localparam int unsigned REF       = 2;
   localparam int          TICK_TMO  = 2 * CLK_HZ + 4;
   localparam int          ANODE_TMO = 4 * REF + 4;

   localparam logic [6:0] MG = 7'b0001100;
   localparam logic [6:0] MY = 7'b0010100;
   localparam logic [6:0] WK = 7'b1100100;
   localparam logic [6:0] SG = 7'b0100001;
   localparam logic [6:0] SY = 7'b0100010;

   typedef struct {
      int         ticks;
      logic       sensor;
      logic       sensor_pulse;
      logic       walk_pulse;
      logic [6:0] leds;
      logic       walk_req;
      int         state;
      int         timer;
   } vec_t;

   logic clk   = 1'b0;
   logic Reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   vec_t vecs[$];

   traffic_light_controller_if bus ();

   traffic_light_controller #(
      .CLK_HZ        (CLK_HZ),
      .REFRESH_CYCLES(REF)
   ) dut (
      .clk  (clk),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0:       return 7'b0000001;
         1:       return 7'b1001111;
         2:       return 7'b0010010;
         3:       return 7'b0000110;
         4:       return 7'b1001100;
         5:       return 7'b0100100;
         6:       return 7'b0100000;
         7:       return 7'b0001111;
         8:       return 7'b0000000;
         9:       return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic void add(input int ticks, input logic sensor, input logic spulse,
                               input logic wpulse, input logic [6:0] leds, input logic wr,
                               input int st, input int tm);
      vec_t v;
      v.ticks = ticks; v.sensor = sensor; v.sensor_pulse = spulse; v.walk_pulse = wpulse;
      v.leds = leds; v.walk_req = wr; v.state = st; v.timer = tm;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance n ticks; returns on the first falling clock edge after OneHz rises.
   task automatic tick_wait(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         int cnt;
         cnt = 0;
         while (bus.OneHz !== 1'b0 && cnt < TICK_TMO) begin @(negedge clk); cnt++; end
         while (bus.OneHz !== 1'b1 && cnt < TICK_TMO) begin @(negedge clk); cnt++; end
         if (cnt >= TICK_TMO) chk({tag, " tick_timeout"}, 32'(bus.OneHz), 32'd1);
      end
   endtask

   task automatic wait_anode(input string tag, input logic [3:0] want);
      int n;
      n = 0;
      while (bus.Anode_Activate !== want && n < ANODE_TMO) begin @(negedge clk); n++; end
      if (bus.Anode_Activate !== want) chk({tag, " anode_wait"}, 32'(bus.Anode_Activate), 32'(want));
   endtask

   task automatic check_disp(input string tag, input int st, input int tm);
      wait_anode(tag, 4'b1110);
      chk({tag, " dig0"}, 32'(bus.LED_out), 32'(seg_of(tm % 10)));
      wait_anode(tag, 4'b1101);
      chk({tag, " dig1"}, 32'(bus.LED_out), 32'(seg_of(tm / 10)));
      wait_anode(tag, 4'b1011);
      chk({tag, " dig2"}, 32'(bus.LED_out), 32'h7F);
      wait_anode(tag, 4'b0111);
      chk({tag, " dig3"}, 32'(bus.LED_out), 32'(seg_of(st)));
   endtask

   task automatic expect_now(input string tag, input logic [6:0] leds, input logic wr,
                             input int st, input int tm);
      chk({tag, " leds"}, 32'(bus.LEDs), 32'(leds));
      chk({tag, " walkreq"}, 32'(bus.WalkReq), 32'(wr));
      check_disp(tag, st, tm);
   endtask

   task automatic reprog(input logic [1:0] sel, input logic [3:0] tv);
      @(negedge clk);
      bus.Selector   = sel;
      bus.Time_Value = tv;
      bus.Reprogram  = 1'b1;
      @(negedge clk);
      bus.Reprogram  = 1'b0;
   endtask

   task automatic pulse_sensor();
      @(negedge clk) bus.Sensor = 1'b1;
      @(negedge clk) bus.Sensor = 1'b0;
   endtask

   task automatic pulse_walk();
      @(negedge clk) bus.WalkRequest = 1'b1;
      repeat (3) @(negedge clk);
      bus.WalkRequest = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " leds"},  32'(bus.LEDs),           32'(MG));
      chk({tag, " anode"}, 32'(bus.Anode_Activate), 32'(4'b1110));
      chk({tag, " seg"},   32'(bus.LED_out),        32'(7'b0100000));
      chk({tag, " walk"},  32'(bus.WalkReq),        32'd0);
      chk({tag, " onehz"}, 32'(bus.OneHz),          32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int tot;
      logic [3:0] an_seq [4];

      bus.Sensor      = 1'b0;
      bus.WalkRequest = 1'b0;
      bus.Reprogram   = 1'b0;
      bus.Selector    = 2'b00;
      bus.Time_Value  = 4'd0;
      #2 Reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // Nominal cycle, no sensor or walk
      add(1, 0, 0, 0, MG, 0, 0, 5);
      add(4, 0, 0, 0, MG, 0, 0, 1);
      add(1, 0, 0, 0, MG, 0, 1, 6);
      add(6, 0, 0, 0, MY, 0, 2, 2);
      add(1, 0, 0, 0, MY, 0, 2, 1);
      add(1, 0, 0, 0, SG, 0, 4, 6);
      add(6, 0, 0, 0, SY, 0, 6, 2);
      add(2, 0, 0, 0, MG, 0, 0, 6);
      // Sensor pulse shortens MAIN_G2; held sensor extends side green
      add(2, 0, 0, 0, MG, 0, 0, 4);
      add(4, 0, 1, 0, MG, 0, 1, 3);
      add(3, 0, 0, 0, MY, 0, 2, 2);
      add(2, 1, 0, 0, SG, 0, 4, 6);
      add(6, 1, 0, 0, SG, 0, 5, 3);
      add(3, 0, 0, 0, SY, 0, 6, 2);
      add(2, 0, 0, 0, MG, 0, 0, 6);
      // Walk request (sensor re-latched during the held side green)
      add(5, 0, 0, 0, MG, 0, 0, 1);
      add(0, 0, 0, 1, MG, 1, 0, 1);
      add(1, 0, 0, 0, MG, 1, 1, 3);
      add(3, 0, 0, 0, MY, 1, 2, 2);
      add(2, 0, 0, 0, WK, 1, 3, 3);
      add(3, 0, 0, 0, SG, 0, 4, 6);
      add(6, 0, 0, 0, SY, 0, 6, 2);
      add(2, 0, 0, 0, MG, 0, 0, 6);

      @(negedge clk) Reset = 1'b1;

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         bus.Sensor = vecs[i].sensor;
         if (vecs[i].sensor_pulse) pulse_sensor();
         if (vecs[i].walk_pulse) pulse_walk();
         tick_wait(tag, vecs[i].ticks);
         expect_now(tag, vecs[i].leds, vecs[i].walk_req, vecs[i].state, vecs[i].timer);
      end

      // Reprogram yellow to 5 s
      reprog(2'b10, 4'd5);
      expect_now("rp_yel5", MG, 0, 0, 6);
      tick_wait("rp_yel5", 6);  expect_now("rp_yel5_g2", MG, 0, 1, 6);
      tick_wait("rp_yel5", 6);  expect_now("rp_yel5_y",  MY, 0, 2, 5);
      tick_wait("rp_yel5", 4);  expect_now("rp_yel5_y1", MY, 0, 2, 1);
      tick_wait("rp_yel5", 1);  expect_now("rp_yel5_sg", SG, 0, 4, 6);
      // Restore defaults from SIDE_G: forced back to MAIN_G
      reprog(2'b11, 4'd9);
      expect_now("rp_def", MG, 0, 0, 6);
      tick_wait("rp_def", 12); expect_now("rp_def_y",  MY, 0, 2, 2);
      tick_wait("rp_def", 2);  expect_now("rp_def_sg", SG, 0, 4, 6);
      // Zero loads as one second
      reprog(2'b10, 4'd0);
      expect_now("rp_zero", MG, 0, 0, 6);
      tick_wait("rp_zero", 12); expect_now("rp_zero_y",  MY, 0, 2, 1);
      tick_wait("rp_zero", 1);  expect_now("rp_zero_sg", SG, 0, 4, 6);
      // Base 3 s, then extension 12 s (two-digit timer)
      reprog(2'b00, 4'd3);
      expect_now("rp_base3", MG, 0, 0, 3);
      tick_wait("rp_base3", 3); expect_now("rp_base3_g2", MG, 0, 1, 3);
      reprog(2'b01, 4'd12);
      expect_now("rp_ext12", MG, 0, 0, 3);
      pulse_sensor();
      tick_wait("rp_ext12", 3); expect_now("rp_ext12_g2", MG, 0, 1, 12);
      tick_wait("rp_ext12", 2); expect_now("rp_ext12_10", MG, 0, 1, 10);

      // Reprogram held across a tick: reprogram wins, timer stays fresh
      @(negedge clk);
      bus.Selector  = 2'b11;
      bus.Reprogram = 1'b1;
      tick_wait("rp_tick", 1);
      bus.Reprogram = 1'b0;
      expect_now("rp_tick", MG, 0, 0, 6);
      tick_wait("rp_tick", 1); expect_now("rp_tick_next", MG, 0, 0, 5);

      // Mid-state asynchronous reset clears parameters and latches
      reprog(2'b10, 4'd5);
      pulse_walk();
      tick_wait("pre_rst", 3);
      expect_now("pre_rst", MG, 1, 0, 3);
      @(posedge clk);
      #2 Reset = 1'b0;
      #1 check_reset_outputs("async_rst");
      repeat (4) @(negedge clk);
      Reset = 1'b1;
      tick_wait("post_rst", 5); expect_now("post_rst_g",  MG, 0, 0, 1);
      tick_wait("post_rst", 1); expect_now("post_rst_g2", MG, 0, 1, 6);
      tick_wait("post_rst", 6); expect_now("post_rst_y",  MY, 0, 2, 2);
      tick_wait("post_rst", 2); expect_now("post_rst_sg", SG, 0, 4, 6);

      // OneHz: 50% duty, period CLK_HZ cycles
      tick_wait("period", 1);
      hi  = 0;
      tot = 0;
      while (bus.OneHz === 1'b1 && tot < TICK_TMO) begin @(negedge clk); hi++; tot++; end
      while (bus.OneHz === 1'b0 && tot < TICK_TMO) begin @(negedge clk); tot++; end
      chk("onehz_high", 32'(hi), 32'(HALF));
      chk("onehz_period", 32'(tot), 32'(CLK_HZ));

      // Anode scan order and dwell
      an_seq[0] = 4'b1101;
      an_seq[1] = 4'b1011;
      an_seq[2] = 4'b0111;
      an_seq[3] = 4'b1110;
      wait_anode("scan", 4'b0111);
      @(negedge clk);
      wait_anode("scan", 4'b1110);
      for (int k = 0; k < 4; k++) begin
         repeat (REF) @(negedge clk);
         chk($sformatf("scan%0d", k), 32'(bus.Anode_Activate), 32'(an_seq[k]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 Parameter CLK_HZ, default 100000, input clock frequency in Hz; sets the 1 Hz tick period.
REQ-002 Parameter REFRESH_CYCLES, default 250, clock cycles each 7-segment digit is driven.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Sensor  input  1  side-street vehicle sensor, level.
REQ-006 WalkRequest  input  1  pedestrian button, pulse of 1+ cycles.
REQ-007 Reprogram  input  1  load Time_Value into the parameter named by Selector.
REQ-008 Selector  input  2  00 tBASE, 01 tEXT, 10 tYEL, 11 restore all defaults.
REQ-009 Time_Value  input  4  new duration in seconds.
REQ-010 LEDs  output  7  [6] walk, [5:3] main R/Y/G, [2:0] side R/Y/G; 1 = lit.
REQ-011 OneHz  output  1  50% duty square wave, period CLK_HZ cycles.
REQ-012 WalkReq  output  1  latched pending walk request.
REQ-013 Anode_Activate  output  4  digit enables, active-low, one-hot-zero.
REQ-014 LED_out  output  7  segments a..g on bits [6:0], active-low.

Function
REQ-015 OneHz toggles every CLK_HZ/2 cycles; its rising edge is the internal tick used by all timing.
REQ-016 Durations tBASE/tEXT/tYEL default 6/3/2 s; on a Reprogram-high clock, Selector 00/01/10 loads Time_Value into that parameter (0 loads as 1), 11 restores defaults; any reprogram also forces state MAIN_G with a fresh timer.
REQ-017 Sensor is latched (sensor_pend) on any cycle it is high; cleared on entry to SIDE_G.
REQ-018 WalkRequest is latched into WalkReq on any cycle it is high; cleared on exit from WALK.
REQ-019 A 4-bit timer is loaded with the new state's duration on state entry, decrements on each tick; the tick that finds timer==1 causes the transition, so each state lasts exactly its duration in seconds.
REQ-020 MAIN_G (LEDs main G, side R): duration tBASE -> MAIN_G2.
REQ-021 MAIN_G2 (main G, side R): duration tEXT if sensor_pend else tBASE -> MAIN_Y; duration is chosen on entry.
REQ-022 MAIN_Y (main Y, side R): tYEL -> WALK if WalkReq else SIDE_G.
REQ-023 WALK (main R, side R, walk lit): tEXT -> SIDE_G.
REQ-024 SIDE_G (main R, side G): tBASE -> SIDE_G2 if Sensor is high at the exit tick, else SIDE_Y.
REQ-025 SIDE_G2 (main R, side G): tEXT -> SIDE_Y.
REQ-026 SIDE_Y (main R, side Y): tYEL -> MAIN_G.
REQ-027 Walk LED lit only in WALK; exactly one of R/Y/G lit per street in every state.
REQ-028 Display: digit0 = timer units (decimal), digit1 = timer tens, digit2 blank (all segments off), digit3 = state index 0..6 (MAIN_G..SIDE_Y); digits scanned 0,1,2,3 cyclically, REFRESH_CYCLES each; hex-style 7-seg decoding of 0-9.
REQ-029 Simultaneous Reprogram and tick: reprogram wins. WalkRequest during WALK re-latches only after exit clears (request arriving in WALK's last cycle is retained).

Reset
REQ-030 While Reset low: state MAIN_G, timer = 6, parameters = defaults, sensor_pend = 0, WalkReq = 0, OneHz = 0, divider and refresh counters = 0.
REQ-031 Outputs during reset: LEDs = 0001100 (main G, side R), Anode_Activate = 1110, LED_out = pattern for "6" (0100000).
REQ-032 Reset asserted mid-state aborts immediately; release resumes from MAIN_G with a full tBASE.

Verification
REQ-033 No Sensor/Walk, defaults: MAIN_G 0-6 s, MAIN_G2 6-12 s, MAIN_Y 12-14 s, SIDE_G 14-20 s, SIDE_Y 20-22 s, MAIN_G again at 22 s.
REQ-034 Sensor pulse at 2 s: MAIN_G2 lasts 3 s, MAIN_Y at 9 s; Sensor held high through 17 s gives SIDE_G 11-17 s, SIDE_G2 17-20 s.
REQ-035 WalkRequest 30 us pulse at 5 s: WalkReq=1 until WALK ends; LEDs = 1100100 for 3 s after MAIN_Y; then WalkReq=0.
REQ-036 Reprogram with Selector=10, Time_Value=5: MAIN_Y lasts 5 s; Selector=11 restores 2 s; Time_Value=0 gives 1 s.
REQ-037 OneHz period exactly CLK_HZ cycles; Anode_Activate cycles 1110,1101,1011,0111 every REFRESH_CYCLES; digit0/1 show timer counting down 6..1.
REQ-038 Reset asserted at 8 s for 20 us: outputs match REQ-031 asynchronously; MAIN_G lasts 6 s after release.
